// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: multi-channel clock-gating controller with request/acknowledge
// wake handshake, idle hysteresis, always-on channels and scan bypass.
`default_nettype none

module clk_gate_ctrl #(
  parameter int                NUM_CH      = 4,
  parameter int                CNT_W       = 8,
  parameter int                IDLE_CYCLES = 8,
  parameter int                WAKE_CYCLES = 2,
  parameter logic [NUM_CH-1:0] AON_MASK    = {NUM_CH{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              test_en,
  output logic [NUM_CH-1:0] ack,
  output logic [NUM_CH-1:0] clk_active,
  output logic [NUM_CH-1:0] gated_clk
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

  if (NUM_CH < 1 || NUM_CH > 16 || CNT_W < 1 || CNT_W > 30 ||
      IDLE_CYCLES < 1 || IDLE_CYCLES > CNT_MAX ||
      WAKE_CYCLES < 1 || WAKE_CYCLES > CNT_MAX) begin : g_param_check
    $error("clk_gate_ctrl: parameter out of range");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_ack;
    logic ch_active;
    logic latch_en;

    if (AON_MASK[i]) begin : g_aon
      logic ready;
      logic unused_req;

      assign unused_req = req[i];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) ready <= 1'b0;
        else     ready <= 1'b1;
      end

      assign ch_ack    = ready;
      assign ch_active = 1'b1;
    end else begin : g_fsm
      localparam logic [1:0] S_OFF  = 2'd0;
      localparam logic [1:0] S_WAKE = 2'd1;
      localparam logic [1:0] S_ON   = 2'd2;
      localparam logic [1:0] S_IDLE = 2'd3;

      logic [1:0]       state;
      logic [1:0]       state_nxt;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] cnt_nxt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state <= S_OFF;
          cnt   <= '0;
        end else begin
          state <= state_nxt;
          cnt   <= cnt_nxt;
        end
      end

      // Counter only advances below its terminal compare, so it never wraps.
      always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
          S_OFF: begin
            if (req[i]) begin
              state_nxt = S_WAKE;
              cnt_nxt   = '0;
            end
          end
          S_WAKE: begin
            if (cnt == WAKE_LAST) begin
              state_nxt = S_ON;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
          S_ON: begin
            if (!req[i]) begin
              state_nxt = S_IDLE;
              cnt_nxt   = '0;
            end
          end
          default: begin
            if (req[i]) begin
              state_nxt = S_ON;
              cnt_nxt   = '0;
            end else if (cnt == IDLE_LAST) begin
              state_nxt = S_OFF;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        endcase
      end

      always_comb begin
        ch_ack    = 1'b0;
        ch_active = 1'b0;
        case (state)
          S_WAKE:  ch_active = 1'b1;
          S_ON,
          S_IDLE: begin
            ch_ack    = 1'b1;
            ch_active = 1'b1;
          end
          default: ;
        endcase
      end
    end

    assign ack[i]        = ch_ack;
    assign clk_active[i] = ch_active;

    // Enable is captured only while clk is low, so a high pulse is never cut short.
    always_latch begin
      if (!clk) latch_en <= ch_active | test_en;
    end

    assign gated_clk[i] = clk & latch_en;
  end

endmodule

`default_nettype wire
